// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: requester and ROM signal bundle for rom_port_arbiter
// slave modport (arbiter side): takes req0/addr0, req1/addr1 and mem_data; drives gnt0/gnt1,
// valid0/valid1, rdata, mem_addr, mem_clk and busy. master modport is the mirror image.
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 48
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              valid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              valid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_clk;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    modport slave (
        input  req0, addr0, req1, addr1, mem_data,
        output gnt0, valid0, gnt1, valid1, rdata, mem_addr, mem_clk, busy
    );
    modport master (
        output req0, addr0, req1, addr1, mem_data,
        input  gnt0, valid0, gnt1, valid1, rdata, mem_addr, mem_clk, busy
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin two-requester arbiter and access sequencer for the single-port image ROM
// Ports: clk (rising edge), rst (synchronous, active-high); bus (slave modport) carries the two
// requester handshakes (req/addr in, gnt/valid out), shared rdata, the registered ROM address,
// the single-cycle ROM clock pulse, ROM read data and the busy flag. Every output is registered.
module rom_port_arbiter #(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 48,
    parameter int unsigned MAX_ADDR = 64800,
    parameter int          ROM_LAT  = 1
) (
    input logic               clk,
    input logic               rst,
    rom_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT} state_t;
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_clk_q, mem_clk_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              valid0_q, valid0_d, valid1_q, valid1_d;
    logic              busy_q;
    logic              win;
    logic              in_range;
    // requester 1 wins when it is alone, or on a tie when requester 0 was served last
    assign win      = bus.req1 & (~bus.req0 | ~last_q);
    assign in_range = 32'(addr_q) < MAX_ADDR;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        mem_clk_d  = 1'b0;
        rdata_d    = rdata_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        valid0_d   = 1'b0;
        valid1_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.req0 | bus.req1) begin
                state_d = SETUP;
                last_d  = win;
                owner_d = win;
                addr_d  = win ? bus.addr1 : bus.addr0;
                gnt0_d  = ~win;
                gnt1_d  = win;
            end
            SETUP: begin
                // out-of-range accesses keep the old ROM address and never clock the ROM
                state_d    = PULSE;
                mem_clk_d  = in_range;
                mem_addr_d = in_range ? addr_q : mem_addr_q;
            end
            PULSE: begin
                state_d = WAIT;
                cnt_d   = 3'd0;
            end
            WAIT: if (cnt_q == 3'(ROM_LAT - 1)) begin
                state_d  = IDLE;
                rdata_d  = in_range ? bus.mem_data : '0;
                valid0_d = ~owner_q;
                valid1_d = owner_q;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            mem_clk_q  <= 1'b0;
            rdata_q    <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            mem_clk_q  <= mem_clk_d;
            rdata_q    <= rdata_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            valid0_q   <= valid0_d;
            valid1_q   <= valid1_d;
            busy_q     <= state_d != IDLE;
        end
    end
    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.valid0   = valid0_q;
    assign bus.valid1   = valid1_q;
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_clk  = mem_clk_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: scoreboard bench running two arbiters (ROM_LAT 1 and 3) under random traffic and resets
module tb_rom_port_arbiter;
    localparam int MAXA = 64800;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    typedef struct {
        int          who;
        int          cyc;
        logic [15:0] addr;
        logic [47:0] data;
    } exp_t;
    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask
    function automatic logic [47:0] rom_word(input logic [15:0] a);
        return {a, a ^ 16'hA5C3, ~a};
    endfunction
    function automatic logic [15:0] pick_addr();
        int s;
        s = int'($urandom_range(0, 9));
        if (s == 0) return 16'(MAXA);
        if (s == 1) return 16'(MAXA - 1);
        if (s == 2) return 16'hFFFF;
        if (s == 3) return 16'h0000;
        if (s == 4) return 16'h0010;
        return 16'($urandom_range(0, 65535));
    endfunction
    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;
        logic rst = 1'b1;
        logic stop = 1'b0;
        logic fin = 1'b0;
        rom_port_arbiter_if #(.ADDR_W(16), .DATA_W(48)) bus ();
        rom_port_arbiter #(.ADDR_W(16), .DATA_W(48), .MAX_ADDR(MAXA), .ROM_LAT(LAT)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
        // ROM model: word for the pulsed address becomes stable LAT cycles after the pulse cycle
        logic [15:0] rom_a = 16'h0;
        int          age = 0;
        always @(posedge clk) begin
            if (bus.mem_clk) begin
                rom_a <= bus.mem_addr;
                age   <= 1;
            end else if (age < 8) begin
                age <= age + 1;
            end
        end
        assign bus.mem_data = (age >= LAT) ? rom_word(rom_a) : ~rom_word(rom_a);
        for (genvar r = 0; r < 2; r++) begin : drv
            logic        v = 1'b0;
            logic [15:0] a = 16'h0;
            logic        gv;
            assign gv = (r == 0) ? bus.gnt0 : bus.gnt1;
            initial begin
                int n;
                v = 1'b1;
                a = pick_addr();
                while (!stop) begin
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!gv && n < 200);
                    chk(gv, $sformatf("L%0d_R%0d_grant_wait", g, r), n, 200);
                    if ($urandom_range(0, 3) == 0) begin
                        v = 1'b0;
                        repeat ($urandom_range(1, 4)) @(negedge clk);
                    end
                    a = pick_addr();
                    v = !stop;
                end
                v = 1'b0;
            end
        end
        assign bus.req0  = drv[0].v;
        assign bus.addr0 = drv[0].a;
        assign bus.req1  = drv[1].v;
        assign bus.addr1 = drv[1].a;
        // reference model: arbiter is free again 3+LAT cycles after a grant decision
        exp_t        gq[$];
        exp_t        pq[$];
        exp_t        vq[$];
        int          cyc = 0;
        int          m_free = 0;
        int          m_gcyc = 0;
        int          m_last = 1;
        logic [15:0] m_mem = 16'h0;
        logic        rst_prev = 1'b1;
        initial forever begin
            int          t, w;
            logic [15:0] ad;
            @(posedge clk);
            t = cyc;
            if (rst) begin
                gq.delete();
                pq.delete();
                vq.delete();
                m_free = t + 1;
                m_gcyc = t;
                m_last = 1;
                m_mem  = 16'h0;
            end else if (t >= m_free && (bus.req0 || bus.req1)) begin
                w  = (bus.req1 && (!bus.req0 || m_last == 0)) ? 1 : 0;
                ad = (w == 1) ? bus.addr1 : bus.addr0;
                gq.push_back('{w, t + 1, ad, 48'h0});
                if (int'(ad) < MAXA) begin
                    pq.push_back('{w, t + 2, ad, 48'h0});
                    vq.push_back('{w, t + 3 + LAT, ad, rom_word(ad)});
                    m_mem = ad;
                end else begin
                    vq.push_back('{w, t + 3 + LAT, ad, 48'h0});
                end
                m_last = w;
                m_gcyc = t;
                m_free = t + 3 + LAT;
            end
            rst_prev = rst;
            cyc = t + 1;
        end
        // monitor: compares DUT outputs against the queued expectations each cycle
        logic [47:0] m_rd = 48'h0;
        initial forever begin
            exp_t e;
            logic eb;
            @(negedge clk);
            if (rst_prev) begin
                chk({bus.gnt0, bus.gnt1, bus.valid0, bus.valid1, bus.mem_clk, bus.busy, bus.mem_addr} == 22'h0,
                    $sformatf("L%0d_reset_ctl", g),
                    {bus.gnt0, bus.gnt1, bus.valid0, bus.valid1, bus.mem_clk, bus.busy, bus.mem_addr}, 0);
                chk(bus.rdata == 48'h0, $sformatf("L%0d_reset_rdata", g), bus.rdata, 0);
                m_rd = 48'h0;
            end else begin
                chk(!(bus.gnt0 && bus.gnt1) && !(bus.valid0 && bus.valid1), $sformatf("L%0d_mutex", g),
                    {bus.gnt0, bus.gnt1, bus.valid0, bus.valid1}, 0);
                eb = cyc > m_gcyc && cyc < m_free;
                chk(bus.busy == eb, $sformatf("L%0d_busy_c%0d", g, cyc), bus.busy, eb);
                if (bus.gnt0 || bus.gnt1) begin
                    if (gq.size() == 0) chk(0, $sformatf("L%0d_unexpected_gnt_c%0d", g, cyc), bus.gnt1, -1);
                    else begin
                        e = gq.pop_front();
                        chk(e.cyc == cyc && e.who == int'(bus.gnt1), $sformatf("L%0d_gnt_cyc_who", g),
                            cyc * 10 + int'(bus.gnt1), e.cyc * 10 + e.who);
                    end
                end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
                    e = gq.pop_front();
                    chk(0, $sformatf("L%0d_missing_gnt", g), cyc, e.cyc);
                end
                if (bus.mem_clk) begin
                    if (pq.size() == 0) chk(0, $sformatf("L%0d_unexpected_mem_clk_c%0d", g, cyc), bus.mem_addr, -1);
                    else begin
                        e = pq.pop_front();
                        chk(e.cyc == cyc && e.addr == bus.mem_addr, $sformatf("L%0d_pulse_cyc_addr", g),
                            cyc * 100000 + int'(bus.mem_addr), e.cyc * 100000 + int'(e.addr));
                    end
                end else if (pq.size() != 0 && pq[0].cyc <= cyc) begin
                    e = pq.pop_front();
                    chk(0, $sformatf("L%0d_missing_mem_clk", g), cyc, e.cyc);
                end
                if (bus.valid0 || bus.valid1) begin
                    if (vq.size() == 0) chk(0, $sformatf("L%0d_unexpected_valid_c%0d", g, cyc), bus.valid1, -1);
                    else begin
                        e = vq.pop_front();
                        chk(e.cyc == cyc && e.who == int'(bus.valid1), $sformatf("L%0d_valid_cyc_who", g),
                            cyc * 10 + int'(bus.valid1), e.cyc * 10 + e.who);
                        chk(bus.rdata == e.data, $sformatf("L%0d_rdata_a%0h", g, e.addr), bus.rdata, e.data);
                        chk(bus.mem_addr == m_mem, $sformatf("L%0d_mem_addr", g), bus.mem_addr, m_mem);
                        m_rd = e.data;
                    end
                end else begin
                    if (vq.size() != 0 && vq[0].cyc <= cyc) begin
                        e = vq.pop_front();
                        chk(0, $sformatf("L%0d_missing_valid", g), cyc, e.cyc);
                    end
                    chk(bus.rdata == m_rd, $sformatf("L%0d_rdata_hold", g), bus.rdata, m_rd);
                end
            end
        end
        // sequencer: initial reset with both requests high, random traffic with occasional mid-access resets
        initial begin
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 1500; k++) begin
                @(negedge clk);
                if ($urandom_range(0, 199) == 0) begin
                    rst = 1'b1;
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                    rst = 1'b0;
                end
            end
            stop = 1'b1;
            repeat (60) @(negedge clk);
            chk(gq.size() + pq.size() + vq.size() == 0, $sformatf("L%0d_drain", g),
                gq.size() + pq.size() + vq.size(), 0);
            fin = 1'b1;
        end
    end
    initial begin
        fork
            wait (lane[0].fin && lane[1].fin);
            begin
                #200000;
                chk(0, "global_timeout", 0, 1);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Two-requester arbiter and access sequencer for the single-port image ROM (48-bit words, two 24-bit pixels each). It sits between the ROM and its consumers: requester 0 is the display pixel loader and requester 1 is the screen/overlay fetcher. It serialises their reads, generates the ROM address and ROM clock pulse, and returns the captured word with a per-requester valid strobe. Round-robin arbitration guarantees that neither requester starves.

## Interface
Parameters:
- ADDR_W, 16, ROM address width.
- DATA_W, 48, ROM word width.
- MAX_ADDR, 64800, first invalid ROM address. Addresses at or above it are out of range.
- ROM_LAT, 1, cycles from the MEM_CLK high cycle to ROM data being stable. Legal range is 1–7.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ0  in  1  requester 0 access request (level).
- ADDR0  in  ADDR_W  requester 0 word address.
- GNT0  out  1  one-cycle pulse: requester 0's address has been accepted.
- VALID0  out  1  one-cycle pulse: RDATA holds requester 0's word.
- REQ1, ADDR1, GNT1, VALID1: same as REQ0, ADDR0, GNT0, VALID0, for requester 1.
- RDATA  out  DATA_W  last captured word, shared by both requesters.
- MEM_ADDR  out  ADDR_W  ROM address (registered).
- MEM_CLK  out  1  ROM clock; one single-cycle high pulse per access.
- MEM_DATA  in  DATA_W  ROM output data.
- BUSY  out  1  high whenever the state is not IDLE.

## Operation
States and transitions:
- IDLE → SETUP when REQ0 or REQ1 is high; otherwise stay in IDLE.
- SETUP → PULSE.
- PULSE → WAIT.
- WAIT → IDLE after ROM_LAT cycles in WAIT.

Arbitration (in IDLE):
- One request high: that requester wins.
- Both high: the requester that is not `last_owner` wins.
- `last_owner` updates to the winner on every grant; its reset value is 1, so requester 0 wins the first tie.

Grant:
- On the grant edge, register the winner's ADDRx into `addr_r` and the owner, and assert GNTx for exactly the next cycle.

Requester protocol:
- Hold ADDRx stable while REQx is high and GNTx has not yet been seen.
- After GNTx, ADDRx may change freely.
- If REQx is still high when the arbiter is next in IDLE, that is a new request.

Access sequence:
- SETUP: MEM_ADDR ← `addr_r`; MEM_CLK = 0.
- PULSE: MEM_CLK = 1.
- WAIT: MEM_CLK = 0. A 3-bit counter counts ROM_LAT cycles.
- On the last WAIT edge: RDATA ← MEM_DATA, and VALIDx (owner) is asserted for the following cycle, which is an IDLE cycle.

Out-of-range address (`addr_r` ≥ MAX_ADDR):
- The FSM runs the same sequence with the same latency.
- MEM_ADDR is not updated and MEM_CLK stays 0.
- RDATA is loaded with 0 and VALIDx still pulses.

Other output rules:
- RDATA and MEM_ADDR hold their values between accesses.
- GNT0/GNT1 are never both high; VALID0/VALID1 are never both high.
- GNTx and VALIDx of different accesses may coincide with IDLE arbitration (see Timing).

Reset (any state, including mid-access):
- State → IDLE; the in-flight access is discarded and no VALID is issued for it.
- Reset values: MEM_CLK=0, MEM_ADDR=0, RDATA=0, GNT0=GNT1=VALID0=VALID1=0, BUSY=0, `last_owner`=1, counter=0.
- REQx is ignored while RESET is high.

## Timing
Request sampled high in IDLE at cycle T:
- T+1: GNTx high; state SETUP.
- T+2: MEM_CLK high.
- T+3 … T+2+ROM_LAT: WAIT.
- T+3+ROM_LAT: VALIDx high, RDATA valid, state IDLE.

Throughput and latency:
- A new grant can be issued at the earliest in T+4+ROM_LAT (its GNT is high then).
- Back-to-back throughput is one access per 3+ROM_LAT cycles.
- Request-to-data latency is 3+ROM_LAT cycles.

All outputs are registered; there are no combinational paths from REQ/ADDR to any output.

## Test plan
- **Reset values:** Assert RESET with REQ0=REQ1=1 → every output holds its reset value. Release at cycle 0 → GNT0 at cycle 2, MEM_CLK high at cycle 3, VALID0 at cycle 5 (ROM_LAT=1).
- **Single read:** REQ0 with ADDR0=0x0010, ROM returns 0xAABBCC112233 → GNT0 at T+1, MEM_ADDR=0x0010 from T+2, exactly one MEM_CLK pulse at T+2, RDATA=0xAABBCC112233 with VALID0 at T+4, no GNT1/VALID1.
- **Round-robin:** REQ0 and REQ1 both held high for 12 accesses → grants alternate 0,1,0,1…, starting with 0. Each access takes 4 cycles. Each VALIDx matches its owner and the data for its address.
- **Out of range:** ADDR1=64800 → VALID1 at T+4 with RDATA=0, no MEM_CLK pulse, MEM_ADDR unchanged. The same test with ADDR1=64799 → a normal access.
- **Latency parameter:** ROM_LAT=3, REQ0 at T → MEM_CLK at T+2, VALID0 at T+6, and the data sampled is the word present at T+5.
- **Reset mid-access:** RESET asserted in PULSE or WAIT → no VALID for the discarded access, all outputs return to reset values the next cycle, and a subsequent REQ1-only request is granted normally.
